rom_fetch_arbiter: RTL and testbench
====================================

// Module: rom_fetch_arbiter
// PURPOSE
// - Shares the single read port of the two-bank instruction ROM between two requesters.
// - Requester 0 is the 6502 core fetch unit. Requester 1 is the debug/loader port.
// - Arbitrates, drives and holds the ROM address, and waits a configurable number of cycles.
// - Captures the 16-bit instruction and returns it with a per-requester valid pulse.
// - Flags addresses outside the two populated banks.
// PARAMETERS
// - ADDR_W       default 16  address width; bits [ADDR_W-1:ADDR_W-2] select the bank.
// - DATA_W       default 16  instruction width.
// - WAIT_STATES  default 0   extra cycles the ROM address is held before capture; legal range 0..7.
// PORTS
// - clk        in   1       rising-edge clock
// - rst_n      in   1       asynchronous active-low reset
// - req0       in   1       requester 0 access request
// - addr0      in   ADDR_W  requester 0 address; stable while req0 is high
// - gnt0       out  1       one-cycle pulse: req0 accepted
// - rvalid0    out  1       one-cycle pulse: rsp_data/rsp_err belong to requester 0
// - req1       in   1       requester 1 access request
// - addr1      in   ADDR_W  requester 1 address
// - gnt1       out  1       one-cycle pulse: req1 accepted
// - rvalid1    out  1       one-cycle pulse: response for requester 1
// - rsp_data   out  DATA_W  registered instruction word; 0 on error
// - rsp_err    out  1       address in unpopulated bank (top bits 01 or 10)
// - rom_addr   out  ADDR_W  registered address to the ROM; held through the access
// - rom_data   in   DATA_W  combinational ROM read data
// - busy       out  1       high in the WAIT state
// BEHAVIOUR
// - Reset values (rst_n low, asynchronous):
//   - gnt0, gnt1, rvalid0, rvalid1, rsp_err, busy = 0; rsp_data = 0; rom_addr = 0.
//   - State = IDLE; last_grant = 1, so req0 wins the first tie.
// - FSM IDLE: requests are sampled at each edge.
//   - If any req is high: pick the winner, register rom_addr = winner address, pulse the winner's gnt for the next cycle.
//   - Also register err_pend = (top bits == 01 or 10); load cnt = WAIT_STATES; go to WAIT.
//   - If no req is high: stay in IDLE.
// - FSM WAIT: req inputs are ignored.
//   - If cnt != 0: decrement cnt.
//   - If cnt == 0: at the edge, rsp_data = err_pend ? 0 : rom_data; rsp_err = err_pend; pulse the winner's rvalid; update last_grant; go to IDLE.
// - Latency: rvalid is high (1 + WAIT_STATES) cycles after gnt.
// - Throughput: one access per (2 + WAIT_STATES) cycles.
// - rsp_data and rsp_err hold their values until the next response. Only rvalid qualifies them.
// - An error access runs the full wait sequence, so latency does not depend on the address.
// - Handshake:
//   - A requester holds req and addr until it sees gnt.
//   - A req still high when the FSM next returns to IDLE is a new access.
//   - Requesters drop req in the gnt cycle for single accesses.
// - Simultaneous req0 and req1 in IDLE: round-robin; grant the requester that is not last_grant.
// - A lone request is always granted, regardless of last_grant.
// - gnt0 and gnt1 are never high together; rvalid0 and rvalid1 are never high together.
// - Reset mid-access: the in-flight access is dropped and no rvalid is issued; everything returns to reset values.
// - Address wrap: no incrementing is done here; the address is passed through unchanged.
// CONFIGURATION
// - Macro FETCH_ARB_FIXED_PRIO_EN.
//   - Defined: requester 0 always wins simultaneous requests; last_grant is unused; requester 1 can starve.
//   - Undefined (default): round-robin as above.
// - All other behaviour is identical with or without the macro.
// TESTING
// - Reset, then req0=1, addr0=16'h0005, WAIT_STATES=0, rom_data=16'hA9F0 ->
//   gnt0 pulses 1 cycle after the sample edge, rom_addr=16'h0005; rvalid0 next cycle, rsp_data=16'hA9F0, rsp_err=0.
// - req1=1 with addr1=16'h4010 (bank 01) -> gnt1, then rvalid1 with rsp_data=0, rsp_err=1; rom_data is ignored.
// - req0 and req1 both held high continuously (round-robin) -> grants alternate 0,1,0,1, one grant every 2 cycles; never both in one cycle.
// - WAIT_STATES=3, req0 with addr0=16'hC002 -> busy high 4 cycles; rvalid0 4 cycles after gnt0; rsp_data = rom_data at the capture edge.
// - rst_n pulled low in the cycle after gnt0 -> no rvalid0 ever appears; all outputs read 0; the next req1 is granted first.
// - FETCH_ARB_FIXED_PRIO_EN defined, both req held high -> only gnt0 pulses; drop req0 -> gnt1 at the next IDLE sample.

Source files
------------

// File: rtl/rom_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// rom_fetch_arbiter
//
// Shares the single read port of the two-bank instruction ROM between the
// 6502 core fetch unit (requester 0) and the debug/loader port (requester 1).
// An access in IDLE registers the winning address onto rom_addr, pulses the
// winner's gnt, then sits in WAIT for WAIT_STATES extra cycles before
// capturing rom_data and pulsing the winner's rvalid. Addresses whose top two
// bits are 01 or 10 fall in unpopulated banks: they run the same sequence but
// return rsp_data = 0 with rsp_err = 1.
//
// Configuration macro:
//   FETCH_ARB_FIXED_PRIO_EN  defined   -> requester 0 always wins ties
//                            undefined -> round-robin on ties (default)
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req0/addr0/gnt0      requester 0 request, address, grant pulse
//   rvalid0              response-valid pulse for requester 0
//   req1/addr1/gnt1      requester 1 request, address, grant pulse
//   rvalid1              response-valid pulse for requester 1
//   rsp_data, rsp_err    registered response word / bank error (held)
//   rom_addr, rom_data   registered ROM address, combinational ROM data
//   busy                 high while the FSM is in WAIT
// -----------------------------------------------------------------------------
module rom_fetch_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
);

  localparam logic [2:0] WAIT_CNT = 3'(WAIT_STATES);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e              state_q,      state_d;
  logic [2:0]          cnt_q,        cnt_d;
  logic                winner_q,     winner_d;     // 1: requester 1 owns the access
  logic                last_grant_q, last_grant_d;
  logic                err_pend_q,   err_pend_d;
  logic [ADDR_W-1:0]   rom_addr_q,   rom_addr_d;
  logic                gnt0_q,       gnt0_d;
  logic                gnt1_q,       gnt1_d;
  logic                rvalid0_q,    rvalid0_d;
  logic                rvalid1_q,    rvalid1_d;
  logic [DATA_W-1:0]   rsp_data_q,   rsp_data_d;
  logic                rsp_err_q,    rsp_err_d;
  logic                busy_q,       busy_d;

  logic                pick1_s;
  logic [ADDR_W-1:0]   addr_sel_s;

  // Banks 00 and 11 are populated; 01 and 10 are holes in the map.
  function automatic logic bank_unpopulated(input logic [1:0] bank);
    return (bank == 2'b01) || (bank == 2'b10);
  endfunction

  // Arbitration: who wins if a request is sampled in IDLE this cycle.
  always_comb begin
    pick1_s = 1'b0;
`ifdef FETCH_ARB_FIXED_PRIO_EN
    pick1_s = req1 & ~req0;
`else
    // A lone req1 wins; on a tie, req1 wins only if req0 had the last grant.
    pick1_s = req1 & (~req0 | ~last_grant_q);
`endif
    if (pick1_s) begin
      addr_sel_s = addr1;
    end else begin
      addr_sel_s = addr0;
    end
  end

  // FSM next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    winner_d     = winner_q;
    last_grant_d = last_grant_q;
    err_pend_d   = err_pend_q;
    rom_addr_d   = rom_addr_q;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    rvalid0_d    = 1'b0;
    rvalid1_d    = 1'b0;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    busy_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          winner_d   = pick1_s;
          rom_addr_d = addr_sel_s;
          gnt0_d     = ~pick1_s;
          gnt1_d     = pick1_s;
          err_pend_d = bank_unpopulated(addr_sel_s[ADDR_W-1:ADDR_W-2]);
          cnt_d      = WAIT_CNT;
          state_d    = ST_WAIT;
          busy_d     = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 3'd0) begin
          cnt_d  = cnt_q - 3'd1;
          busy_d = 1'b1;
        end else begin
          // Error accesses still take the full wait so latency is address-independent.
          if (err_pend_q) begin
            rsp_data_d = {DATA_W{1'b0}};
          end else begin
            rsp_data_d = rom_data;
          end
          rsp_err_d    = err_pend_q;
          rvalid0_d    = ~winner_q;
          rvalid1_d    = winner_q;
          last_grant_d = winner_q;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      winner_q     <= 1'b0;
      last_grant_q <= 1'b1;
      err_pend_q   <= 1'b0;
      rom_addr_q   <= {ADDR_W{1'b0}};
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rsp_data_q   <= {DATA_W{1'b0}};
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      winner_q     <= winner_d;
      last_grant_q <= last_grant_d;
      err_pend_q   <= err_pend_d;
      rom_addr_q   <= rom_addr_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;
  assign rom_addr = rom_addr_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rom_fetch_arbiter
//
// Directed bench for rom_fetch_arbiter. Instance u_dut_a uses WAIT_STATES=0,
// u_dut_b uses WAIT_STATES=3. Each ROM is modelled as rom_addr XOR a constant,
// so expected data are hand-computed from the address.
// -----------------------------------------------------------------------------
module tb_rom_fetch_arbiter;

  logic        clk;
  logic        rst_n;

  logic        req0_a, req1_a, gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, rsp_err_a, busy_a;
  logic [15:0] addr0_a, addr1_a, rsp_data_a, rom_addr_a, rom_data_a;

  logic        req0_b, req1_b, gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, rsp_err_b, busy_b;
  logic [15:0] addr0_b, addr1_b, rsp_data_b, rom_addr_b, rom_data_b;

  int          n_tests;
  int          n_fail;

  assign rom_data_a = rom_addr_a ^ 16'hA9F5;
  assign rom_data_b = rom_addr_b ^ 16'h1234;

  rom_fetch_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .req0(req0_a), .addr0(addr0_a), .gnt0(gnt0_a), .rvalid0(rvalid0_a),
    .req1(req1_a), .addr1(addr1_a), .gnt1(gnt1_a), .rvalid1(rvalid1_a),
    .rsp_data(rsp_data_a), .rsp_err(rsp_err_a),
    .rom_addr(rom_addr_a), .rom_data(rom_data_a), .busy(busy_a)
  );

  rom_fetch_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0(req0_b), .addr0(addr0_b), .gnt0(gnt0_b), .rvalid0(rvalid0_b),
    .req1(req1_b), .addr1(addr1_b), .gnt1(gnt1_b), .rvalid1(rvalid1_b),
    .rsp_data(rsp_data_b), .rsp_err(rsp_err_b),
    .rom_addr(rom_addr_b), .rom_data(rom_data_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_g0;
    logic [7:0] exp_g1;
    int         lat;
    int         busy_cycles;
    logic       seen;

    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    req0_a = 1'b0; req1_a = 1'b0; addr0_a = 16'h0000; addr1_a = 16'h0000;
    req0_b = 1'b0; req1_b = 1'b0; addr0_b = 16'h0000; addr1_b = 16'h0000;

    // ---- reset values
    tick();
    tick();
    check_eq("rst_gnt",    {30'd0, gnt1_a, gnt0_a}, 32'd0);
    check_eq("rst_rvalid", {30'd0, rvalid1_a, rvalid0_a}, 32'd0);
    check_eq("rst_err",    {31'd0, rsp_err_a}, 32'd0);
    check_eq("rst_busy",   {31'd0, busy_a}, 32'd0);
    check_eq("rst_data",   {16'd0, rsp_data_a}, 32'd0);
    check_eq("rst_addr",   {16'd0, rom_addr_a}, 32'd0);
    rst_n = 1'b1;
    tick();

    // ---- single req0 access, no wait states
    req0_a = 1'b1; addr0_a = 16'h0005;
    tick();
    check_eq("t1_gnt0",     {31'd0, gnt0_a}, 32'd1);
    check_eq("t1_gnt1",     {31'd0, gnt1_a}, 32'd0);
    check_eq("t1_rom_addr", {16'd0, rom_addr_a}, 32'h0005);
    check_eq("t1_busy",     {31'd0, busy_a}, 32'd1);
    req0_a = 1'b0;
    tick();
    check_eq("t1_gnt0_off", {31'd0, gnt0_a}, 32'd0);
    check_eq("t1_rvalid0",  {31'd0, rvalid0_a}, 32'd1);
    check_eq("t1_data",     {16'd0, rsp_data_a}, 32'hA9F0);
    check_eq("t1_err",      {31'd0, rsp_err_a}, 32'd0);
    check_eq("t1_busy_off", {31'd0, busy_a}, 32'd0);
    tick();
    check_eq("t1_rvalid0_off", {31'd0, rvalid0_a}, 32'd0);
    check_eq("t1_data_hold",   {16'd0, rsp_data_a}, 32'hA9F0);

    // ---- req1 into unpopulated bank 01
    req1_a = 1'b1; addr1_a = 16'h4010;
    tick();
    check_eq("t2_gnt1",     {31'd0, gnt1_a}, 32'd1);
    check_eq("t2_gnt0",     {31'd0, gnt0_a}, 32'd0);
    check_eq("t2_rom_addr", {16'd0, rom_addr_a}, 32'h4010);
    req1_a = 1'b0;
    tick();
    check_eq("t2_rvalid1",  {31'd0, rvalid1_a}, 32'd1);
    check_eq("t2_rvalid0",  {31'd0, rvalid0_a}, 32'd0);
    check_eq("t2_data",     {16'd0, rsp_data_a}, 32'h0000);
    check_eq("t2_err",      {31'd0, rsp_err_a}, 32'd1);
    tick();

    // ---- both requests held: last grant was 1, so 0 goes first
    req0_a = 1'b1; addr0_a = 16'h0100;
    req1_a = 1'b1; addr1_a = 16'hC200;
`ifdef FETCH_ARB_FIXED_PRIO_EN
    exp_g0 = 8'b0101_0101;
    exp_g1 = 8'b0000_0000;
`else
    exp_g0 = 8'b0001_0001;
    exp_g1 = 8'b0100_0100;
`endif
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq($sformatf("rr_gnt0_c%0d", i), {31'd0, gnt0_a}, {31'd0, exp_g0[i]});
      check_eq($sformatf("rr_gnt1_c%0d", i), {31'd0, gnt1_a}, {31'd0, exp_g1[i]});
      check_eq($sformatf("rr_excl_c%0d", i), {31'd0, gnt0_a & gnt1_a}, 32'd0);
      if (i == 1) begin
        check_eq("rr_data0", {16'd0, rsp_data_a}, 32'hA8F5);
      end
`ifndef FETCH_ARB_FIXED_PRIO_EN
      if (i == 3) begin
        check_eq("rr_rvalid1", {31'd0, rvalid1_a}, 32'd1);
        check_eq("rr_data1",   {16'd0, rsp_data_a}, 32'h6BF5);
      end
`endif
    end
    req0_a = 1'b0; req1_a = 1'b0;
    tick();
    tick();

    // ---- WAIT_STATES=3 instance, bank 11
    req0_b = 1'b1; addr0_b = 16'hC002;
    tick();
    check_eq("ws_gnt0", {31'd0, gnt0_b}, 32'd1);
    req0_b = 1'b0;
    busy_cycles = (busy_b === 1'b1) ? 1 : 0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (rvalid0_b === 1'b1) begin
        lat = n;
        break;
      end
      if (busy_b === 1'b1) busy_cycles = busy_cycles + 1;
    end
    check_eq("ws_latency", lat, 32'd4);
    check_eq("ws_busy",    busy_cycles, 32'd4);
    check_eq("ws_data",    {16'd0, rsp_data_b}, 32'hD236);
    check_eq("ws_err",     {31'd0, rsp_err_b}, 32'd0);
    check_eq("ws_busy_off", {31'd0, busy_b}, 32'd0);
    tick();

    // ---- reset in the cycle after gnt0
    req0_a = 1'b1; addr0_a = 16'h0007;
    tick();
    check_eq("mr_gnt0", {31'd0, gnt0_a}, 32'd1);
    req0_a = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_eq("mr_gnt0_clr", {31'd0, gnt0_a}, 32'd0);
    check_eq("mr_busy_clr", {31'd0, busy_a}, 32'd0);
    check_eq("mr_data_clr", {16'd0, rsp_data_a}, 32'd0);
    check_eq("mr_addr_clr", {16'd0, rom_addr_a}, 32'd0);
    tick();
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (rvalid0_a === 1'b1 || rvalid1_a === 1'b1) seen = 1'b1;
    end
    check_eq("mr_no_rvalid", {31'd0, seen}, 32'd0);
    req1_a = 1'b1; addr1_a = 16'h0020;
    tick();
    check_eq("mr_gnt1", {31'd0, gnt1_a}, 32'd1);
    check_eq("mr_rom_addr", {16'd0, rom_addr_a}, 32'h0020);
    req1_a = 1'b0;
    tick();
    check_eq("mr_rvalid1", {31'd0, rvalid1_a}, 32'd1);
    check_eq("mr_data",    {16'd0, rsp_data_a}, 32'hA9D5);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
